// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for one side of a pipeline stage: valid/ready plus the
// control field, data payload and destination-register index.
interface pipe_stage_buf_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;
  logic [RD_W-1:0]   rd;

  // Producer side drives the entry, consumer side returns ready.
  modport master (output valid, ctrl, data, rd, input  ready);
  modport slave  (input  valid, ctrl, data, rd, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional one-entry
// skid buffer, freeze (halt_i) and flush. The control field is forced to
// zero whenever the head slot is not valid, so hazard logic downstream can
// use it without qualifying by valid.
module pipe_stage_buf #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter bit SKID   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  halt_i,
  input  logic                  flush_i,
  pipe_stage_buf_if.slave       up,
  pipe_stage_buf_if.master      dn,
  output logic [1:0]            occ_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [RD_W-1:0]   main_rd_q,   skid_rd_q;

  logic active;
  logic valid;
  logic ready;
  logic accept;
  logic take;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Halt and flush both hide the stage from both neighbours, so neither
  // side can complete a handshake in such a cycle.
  assign active = !halt_i && !flush_i;
  assign valid  = (state_q != EMPTY) && active;

  generate
    if (SKID) begin : g_skid
      // Registered ready: only the occupancy state and halt/flush matter,
      // which breaks the ready chain between stages.
      assign ready = (state_q != TWO) && active;
    end else begin : g_no_skid
      // Single entry: can refill in the same cycle the head is drained.
      assign ready = ((state_q == EMPTY) || dn.ready) && active;
    end
  endgenerate

  assign accept = up.valid && ready;
  assign take   = valid && dn.ready;

  // Next-state and load-enable decode for the occupancy FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      // During halt accept and take are both low, so nothing below fires.
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && take) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            // Only reachable with the skid buffer: without it, accepting in
            // ONE requires ready_i and therefore implies a take.
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // ready is low in TWO, so the only event is draining the head;
          // the skid entry moves forward to keep FIFO order.
          if (take) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry registers; flush clears only the stored control bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: the payload registers are reset too, because data_o and rd_o
      // show the main register unconditionally and must read 0 after reset.
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_rd_q   <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples values from before this edge regardless of statement order.
      state_q <= state_d;
      if (flush_i) begin
        main_ctrl_q <= '0;
        skid_ctrl_q <= '0;
      end else begin
        if (load_main_in) begin
          main_ctrl_q <= up.ctrl;
          main_data_q <= up.data;
          main_rd_q   <= up.rd;
        end else if (load_main_skid) begin
          main_ctrl_q <= skid_ctrl_q;
          main_data_q <= skid_data_q;
          main_rd_q   <= skid_rd_q;
        end
        if (load_skid) begin
          skid_ctrl_q <= up.ctrl;
          skid_data_q <= up.data;
          skid_rd_q   <= up.rd;
        end
      end
    end
  end

  assign up.ready = ready;
  assign dn.valid = valid;
  assign dn.ctrl  = valid ? main_ctrl_q : '0;
  assign dn.data  = main_data_q;
  assign dn.rd    = main_rd_q;
  assign occ_o    = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one instance with the skid buffer (index 0) and
// one without (index 1). Directed beats push expected entries into a
// per-instance queue; a monitor pops and compares whenever an output is taken.
module tb_pipe_stage_buf;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [63:0] data;
    logic [4:0]  rd;
  } ent_t;

  logic clk;
  logic rst_n;

  logic        v_in     [2];
  logic [3:0]  c_in     [2];
  logic [63:0] d_in     [2];
  logic [4:0]  r_in     [2];
  logic        rdy_in   [2];
  logic        halt_in  [2];
  logic        flush_in [2];

  logic        vo   [2];
  logic        ro   [2];
  logic [3:0]  co   [2];
  logic [63:0] dout [2];
  logic [4:0]  rout [2];
  logic [1:0]  occ  [2];
  logic [1:0]  occ0, occ1;

  ent_t q0[$];
  ent_t q1[$];
  ent_t mon_e;
  int   tk [2];
  int   n_checks;
  int   n_fail;

  pipe_stage_buf_if #(.CTRL_W(4), .DATA_W(64), .RD_W(5)) up0 ();
  pipe_stage_buf_if #(.CTRL_W(4), .DATA_W(64), .RD_W(5)) dn0 ();
  pipe_stage_buf_if #(.CTRL_W(4), .DATA_W(64), .RD_W(5)) up1 ();
  pipe_stage_buf_if #(.CTRL_W(4), .DATA_W(64), .RD_W(5)) dn1 ();

  assign up0.valid = v_in[0];
  assign up0.ctrl  = c_in[0];
  assign up0.data  = d_in[0];
  assign up0.rd    = r_in[0];
  assign dn0.ready = rdy_in[0];
  assign up1.valid = v_in[1];
  assign up1.ctrl  = c_in[1];
  assign up1.data  = d_in[1];
  assign up1.rd    = r_in[1];
  assign dn1.ready = rdy_in[1];

  assign vo[0]   = dn0.valid;
  assign ro[0]   = up0.ready;
  assign co[0]   = dn0.ctrl;
  assign dout[0] = dn0.data;
  assign rout[0] = dn0.rd;
  assign occ[0]  = occ0;
  assign vo[1]   = dn1.valid;
  assign ro[1]   = up1.ready;
  assign co[1]   = dn1.ctrl;
  assign dout[1] = dn1.data;
  assign rout[1] = dn1.rd;
  assign occ[1]  = occ1;

  pipe_stage_buf #(.CTRL_W(4), .DATA_W(64), .RD_W(5), .SKID(1'b1)) u_dut_skid (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .halt_i  (halt_in[0]),
    .flush_i (flush_in[0]),
    .up      (up0),
    .dn      (dn0),
    .occ_o   (occ0)
  );

  pipe_stage_buf #(.CTRL_W(4), .DATA_W(64), .RD_W(5), .SKID(1'b0)) u_dut_noskid (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .halt_i  (halt_in[1]),
    .flush_i (flush_in[1]),
    .up      (up1),
    .dn      (dn1),
    .occ_o   (occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void push(int d, logic [3:0] c, logic [63:0] dt, logic [4:0] r);
    ent_t e;
    e.ctrl = c;
    e.data = dt;
    e.rd   = r;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // One clock cycle of stimulus on instance d, with the hand-derived
  // ready_o, valid_o and occupancy expected before the closing edge.
  task automatic beat(int d, logic v, logic [3:0] c, logic [63:0] dt, logic [4:0] r,
                      logic rdy, logic exp_ready, logic exp_valid, int exp_occ);
    v_in[d]   = v;
    c_in[d]   = c;
    d_in[d]   = dt;
    r_in[d]   = r;
    rdy_in[d] = rdy;
    @(negedge clk);
    check($sformatf("ready_o[%0d]", d), 64'(ro[d]), 64'(exp_ready));
    check($sformatf("valid_o[%0d]", d), 64'(vo[d]), 64'(exp_valid));
    check($sformatf("occ_o[%0d]", d), 64'(occ[d]), 64'(exp_occ));
    if (v && exp_ready) push(d, c, dt, r);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares every taken output, and checks the
  // ctrl masking and SKID=0 ready properties on every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (!vo[d]) check($sformatf("ctrl_masked[%0d]", d), 64'(co[d]), 64'd0);
        if (vo[d] && rdy_in[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_out[%0d] data", d), dout[d], 64'hDEAD_0000_0000_0000);
          end else begin
            if (d == 0) mon_e = q0.pop_front();
            else        mon_e = q1.pop_front();
            check($sformatf("out_ctrl[%0d]", d), 64'(co[d]), 64'(mon_e.ctrl));
            check($sformatf("out_data[%0d]", d), dout[d], mon_e.data);
            check($sformatf("out_rd[%0d]", d), 64'(rout[d]), 64'(mon_e.rd));
            tk[d]++;
          end
        end
      end
      check("noskid_occ_le_1", 64'(occ1 > 2'd1), 64'd0);
      if (occ1 == 2'd1 && !halt_in[1] && !flush_in[1])
        check("noskid_ready_follows", 64'(ro[1]), 64'(rdy_in[1]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tk_before;
    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < 2; d++) begin
      v_in[d] = 1'b0; c_in[d] = '0; d_in[d] = '0; r_in[d] = '0;
      rdy_in[d] = 1'b0; halt_in[d] = 1'b0; flush_in[d] = 1'b0;
      tk[d] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_occ", 64'(occ0), 64'd0);
    check("reset_valid", 64'(vo[0]), 64'd0);
    check("reset_ctrl", 64'(co[0]), 64'd0);
    check("reset_data", dout[0], 64'd0);
    check("reset_rd", 64'(rout[0]), 64'd0);
    check("reset_data_noskid", dout[1], 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(ro[0]), 64'd1);
    check("post_reset_ready_noskid", 64'(ro[1]), 64'd1);
    @(posedge clk);
    #1;

    // Streaming, skid build: one entry per cycle, occupancy 1 throughout.
    for (int i = 1; i <= 8; i++)
      beat(0, 1'b1, 4'hF, 64'(i), 5'(i), 1'b1, 1'b1, i > 1, (i > 1) ? 1 : 0);
    beat(0, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b1, 1'b1, 1);
    beat(0, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b1, 1'b0, 0);
    check("stream_taken", 64'(tk[0]), 64'd8);

    // Backpressure, skid build: ready_i low for three cycles.
    beat(0, 1'b1, 4'h1, 64'h11, 5'd1, 1'b1, 1'b1, 1'b0, 0);
    beat(0, 1'b1, 4'h2, 64'h22, 5'd2, 1'b0, 1'b1, 1'b1, 1);
    beat(0, 1'b1, 4'h3, 64'h33, 5'd3, 1'b0, 1'b0, 1'b1, 2);
    beat(0, 1'b1, 4'h3, 64'h33, 5'd3, 1'b0, 1'b0, 1'b1, 2);
    beat(0, 1'b1, 4'h3, 64'h33, 5'd3, 1'b1, 1'b0, 1'b1, 2);
    beat(0, 1'b1, 4'h3, 64'h33, 5'd3, 1'b1, 1'b1, 1'b1, 1);
    beat(0, 1'b1, 4'h4, 64'h44, 5'd4, 1'b1, 1'b1, 1'b1, 1);
    beat(0, 1'b0, 4'h0, 64'h0,  5'd0, 1'b1, 1'b1, 1'b1, 1);
    beat(0, 1'b0, 4'h0, 64'h0,  5'd0, 1'b1, 1'b1, 1'b0, 0);
    check("bp_taken", 64'(tk[0]), 64'd12);

    // Halt for four cycles with one entry held.
    beat(0, 1'b1, 4'h3, 64'h1234, 5'd7, 1'b0, 1'b1, 1'b0, 0);
    tk_before = tk[0];
    halt_in[0] = 1'b1;
    for (int i = 0; i < 4; i++)
      beat(0, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1);
    halt_in[0] = 1'b0;
    beat(0, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b1, 1'b1, 1);
    beat(0, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b1, 1'b0, 0);
    check("halt_presented_once", 64'(tk[0] - tk_before), 64'd1);

    // Flush with two entries held and a valid input in the flush cycle.
    beat(0, 1'b1, 4'hA, 64'hA0, 5'd10, 1'b0, 1'b1, 1'b0, 0);
    beat(0, 1'b1, 4'h5, 64'h50, 5'd5,  1'b0, 1'b1, 1'b1, 1);
    flush_in[0] = 1'b1;
    beat(0, 1'b1, 4'hC, 64'hC0, 5'd12, 1'b1, 1'b0, 1'b0, 2);
    flush_in[0] = 1'b0;
    q0.delete();
    beat(0, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b1, 1'b0, 0);
    check("flush_data_retained", dout[0], 64'hA0);
    check("flush_rd_retained", 64'(rout[0]), 64'd10);
    beat(0, 1'b1, 4'h9, 64'h99, 5'd9, 1'b1, 1'b1, 1'b0, 0);
    beat(0, 1'b0, 4'h0, 64'h0,  5'd0, 1'b1, 1'b1, 1'b1, 1);
    beat(0, 1'b0, 4'h0, 64'h0,  5'd0, 1'b1, 1'b1, 1'b0, 0);

    // Flush and halt together: flush wins and empties the stage.
    beat(0, 1'b1, 4'h6, 64'h66, 5'd6, 1'b0, 1'b1, 1'b0, 0);
    halt_in[0]  = 1'b1;
    flush_in[0] = 1'b1;
    beat(0, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1);
    halt_in[0]  = 1'b0;
    flush_in[0] = 1'b0;
    q0.delete();
    beat(0, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b1, 1'b0, 0);

    // Asynchronous reset with two entries held, asserted mid-cycle.
    beat(0, 1'b1, 4'h7, 64'h77, 5'd17, 1'b0, 1'b1, 1'b0, 0);
    beat(0, 1'b1, 4'h8, 64'h88, 5'd18, 1'b0, 1'b1, 1'b1, 1);
    v_in[0] = 1'b0;
    check("pre_reset_occ", 64'(occ0), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_occ", 64'(occ0), 64'd0);
    check("async_reset_valid", 64'(vo[0]), 64'd0);
    check("async_reset_ctrl", 64'(co[0]), 64'd0);
    check("async_reset_data", dout[0], 64'd0);
    check("async_reset_rd", 64'(rout[0]), 64'd0);
    q0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", 64'(ro[0]), 64'd1);
    @(posedge clk);
    #1;
    rdy_in[0] = 1'b0;

    // Streaming, single-entry build.
    for (int i = 1; i <= 8; i++)
      beat(1, 1'b1, 4'hF, 64'(i), 5'(i), 1'b1, 1'b1, i > 1, (i > 1) ? 1 : 0);
    beat(1, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b1, 1'b1, 1);
    beat(1, 1'b0, 4'h0, 64'h0, 5'd0, 1'b1, 1'b1, 1'b0, 0);
    check("noskid_stream_taken", 64'(tk[1]), 64'd8);

    // Backpressure, single-entry build: ready_o drops with ready_i.
    beat(1, 1'b1, 4'h1, 64'h11, 5'd1, 1'b1, 1'b1, 1'b0, 0);
    beat(1, 1'b1, 4'h2, 64'h22, 5'd2, 1'b0, 1'b0, 1'b1, 1);
    beat(1, 1'b1, 4'h2, 64'h22, 5'd2, 1'b0, 1'b0, 1'b1, 1);
    beat(1, 1'b1, 4'h2, 64'h22, 5'd2, 1'b0, 1'b0, 1'b1, 1);
    beat(1, 1'b1, 4'h2, 64'h22, 5'd2, 1'b1, 1'b1, 1'b1, 1);
    beat(1, 1'b1, 4'h3, 64'h33, 5'd3, 1'b1, 1'b1, 1'b1, 1);
    beat(1, 1'b0, 4'h0, 64'h0,  5'd0, 1'b1, 1'b1, 1'b1, 1);
    beat(1, 1'b0, 4'h0, 64'h0,  5'd0, 1'b1, 1'b1, 1'b0, 0);

    check("final_taken_skid", 64'(tk[0]), 64'd14);
    check("final_taken_noskid", 64'(tk[1]), 64'd11);
    check("final_queue_skid", 64'(q0.size()), 64'd0);
    check("final_queue_noskid", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake, an optional one-entry skid buffer, freeze (halt) and flush. It replaces the fixed-width stall-only stage latches between execute, memory and write-back. The stage carries a control field, a data payload and a destination-register index. Control bits are never presented downstream for an empty or killed slot, so hazard and forwarding logic can read `ctrl_o` unqualified.

## Interface
- `CTRL_W`, default 4: control field width (WB + M bits).
- `DATA_W`, default 64: payload width (e.g. address ‖ store data).
- `RD_W`, default 5: destination register index width.
- `SKID`, default 1: 1 = two-entry (main + skid, fully registered `ready_o`); 0 = single entry, combinational `ready_o`.
- `clk_i` input 1: single clock; all state on rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `halt_i` input 1: global freeze; no state change.
- `flush_i` input 1: kill all held entries.
- `valid_i` input 1: upstream entry valid.
- `ready_o` output 1: stage can accept.
- `ctrl_i` input CTRL_W: upstream control.
- `data_i` input DATA_W: upstream payload.
- `rd_i` input RD_W: upstream destination index.
- `valid_o` output 1: downstream entry valid.
- `ready_i` input 1: downstream can accept.
- `ctrl_o` output CTRL_W: control; forced 0 whenever `valid_o`=0.
- `data_o` output DATA_W: payload of head entry.
- `rd_o` output RD_W: destination index of head entry.
- `occ_o` output 2: entries held (0..2).

## Operation
- Accept = `valid_i & ready_o`. Take = `valid_o & ready_i`.
- States: EMPTY (occ 0), ONE (main valid), TWO (main + skid valid; SKID=1 only).
- EMPTY: accept → ONE, main ← inputs.
- ONE, accept & take → ONE, main ← inputs.
- ONE, accept & !take → TWO, skid ← inputs (SKID=1 only).
- ONE, !accept & take → EMPTY.
- TWO, take → ONE, main ← skid. Accept is impossible in TWO.
- `ready_o`, SKID=1: `state != TWO & !halt_i & !flush_i`.
- `ready_o`, SKID=0: `(state==EMPTY | ready_i) & !halt_i & !flush_i`.
- `valid_o` = `state != EMPTY & !halt_i & !flush_i`.
- Head entry: `data_o`/`rd_o` always show the main register. `ctrl_o` = main ctrl when `valid_o`, else 0.
- Priority: `rst_i` > `flush_i` > `halt_i` > handshake.
- `flush_i` at an edge: state → EMPTY, stored ctrl of both entries cleared, data/rd retained. No accept or take happens in a flush cycle.
- `halt_i` at an edge: all state held. `valid_o`/`ready_o` are low, so no handshake is counted on either side.
- `ctrl_i` is stored unmasked; only entries accepted with `valid_i`=1 are ever stored.

## Timing
- Reset (async assert, sync deassert by system) values:
  - state EMPTY, `occ_o`=0;
  - `valid_o`=0, `ctrl_o`=0, `data_o`=0, `rd_o`=0;
  - `ready_o`=1 when `halt_i`=`flush_i`=0.
- Latency: an entry accepted at edge N appears on `valid_o` after edge N (1 cycle) if the stage was EMPTY, or was ONE and taken at N.
- Throughput: 1 entry/cycle sustained while `ready_i`=1, for both SKID values.
- SKID=1: `ready_o` depends only on registered state plus `halt_i`/`flush_i`, with no path from `ready_i`. A `ready_i` drop costs no data; the in-flight entry lands in skid.
- SKID=0: combinational path `ready_i` → `ready_o`.
- Reset mid-operation: both entries discarded immediately (asynchronous); outputs take reset values before the next edge.
- Simultaneous `flush_i` and `halt_i`: flush wins.
- Simultaneous `flush_i` with `valid_i`: the input is dropped.
- Order is strictly FIFO: skid content is never overtaken by a newer input.

## Test plan
- **Reset:** drive `rst_i`=0 mid-stream with occ=2 → outputs go 0 asynchronously, `occ_o`=0; after release, `ready_o`=1.
- **Streaming:** `ready_i`=1, 8 back-to-back entries with data 0x1..0x8, ctrl 0xF, rd 1..8 → `valid_o` 1 cycle later, same order, one per cycle, `occ_o`=1 throughout.
- **Backpressure (SKID=1):** drop `ready_i` for 3 cycles while `valid_i`=1 → `occ_o` 1→2, `ready_o`=0 the cycle after the second accept. On `ready_i`=1, entries drain in order with no loss or duplication.
- **Flush:** with occ=2 (ctrl 0xA, 0x5), assert `flush_i` one cycle with `valid_i`=1 → `ready_o`=`valid_o`=0 that cycle, `ctrl_o`=0, `occ_o`=0 next cycle. The flushed entries and the dropped input never appear.
- **Halt:** assert `halt_i` 4 cycles with occ=1, `ready_i`=1 → `valid_o`=`ready_o`=0 and `ctrl_o`=0 during the halt. After release, the same entry (data 0x1234, rd 7) is presented once.
- **SKID=0 build:** repeat the streaming and backpressure scenarios → `occ_o` never exceeds 1, and `ready_o` follows `ready_i` in the same cycle while occupied.
